// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch buffer between PC stage and decode
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int IW    = 32
) (
   input  logic                     clock_in,
   input  logic                     reset,
   input  logic [AW-1:0]            pc_in,
   input  logic                     pc_valid,
   output logic                     pc_ready,
   output logic [AW-1:0]            imem_addr,
   output logic                     imem_rd,
   input  logic [IW-1:0]            imem_data,
   input  logic                     flush,
   output logic [IW-1:0]            inst_out,
   output logic [AW-1:0]            inst_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // Occupancy is one bit wider than count so count + pending never wraps.
   localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

   logic [IW-1:0] mem_inst [DEPTH];
   logic [AW-1:0] mem_pc   [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          pending;
   logic [AW-1:0] pend_pc;
   logic          accept;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;

   // Slots already promised to stored entries plus the read in flight;
   // a same-cycle pop deliberately does not free a slot here.
   assign occupancy  = {1'b0, count} + {{CW{1'b0}}, pending};
   assign pc_ready   = reset && !flush && (occupancy < DEPTH_OCC);
   assign accept     = pc_valid && pc_ready;
   assign imem_rd    = accept;
   assign imem_addr  = pc_in;

   assign inst_valid = (count != '0);
   assign inst_out   = mem_inst[head];
   assign inst_pc    = mem_pc[head];

   // A response is captured only if it was not cancelled by a flush this cycle.
   assign push       = pending && !flush;
   assign pop        = inst_valid && inst_ready && !flush;

   // Track the single outstanding memory read and the PC it belongs to.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         pending <= 1'b0;
         pend_pc <= '0;
      end else if (flush) begin
         pending <= 1'b0;
      end else begin
         pending <= accept;
         if (accept) begin
            pend_pc <= pc_in;
         end
      end
   end

   // Head/tail pointers and occupancy count; flush empties the queue.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage: returned word paired with its fetch PC, written at the tail.
   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_inst[i] <= '0;
            mem_pc[i]   <= '0;
         end
      end else if (push) begin
         mem_inst[tail] <= imem_data;
         mem_pc[tail]   <= pend_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic [31:0] imem_addr;
   logic        imem_rd;
   logic [31:0] imem_data;
   logic        flush;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [2:0]  count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   exp_t exp_e;

   int checks = 0;
   int fails  = 0;

   logic        last_acc;
   logic        last_pop;
   logic        last_rdy;
   logic        last_valid;
   logic [2:0]  last_cnt;
   logic [31:0] got_pc;
   logic [31:0] got_inst;

   fetch_queue #(.DEPTH(4), .AW(32), .IW(32)) dut (
      .clock_in   (clk),
      .reset      (rst_n),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .imem_addr  (imem_addr),
      .imem_rd    (imem_rd),
      .imem_data  (imem_data),
      .flush      (flush),
      .inst_out   (inst_out),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: word = 0x1000_0000 + address, garbage when not read.
   always @(posedge clk) begin
      if (imem_rd) imem_data <= 32'h1000_0000 + imem_addr;
      else         imem_data <= 32'hDEAD_BEEF;
   end

   // One cycle: drive inputs at the falling edge, sample 1ns later, record
   // expectations for accepts, then advance to the next falling edge.
   task automatic drive_cycle(input logic pv, input logic [31:0] pc,
                              input logic ir, input logic fl);
      pc_valid   = pv;
      pc_in      = pc;
      inst_ready = ir;
      flush      = fl;
      #1;
      last_acc   = pc_valid && pc_ready;
      last_rdy   = pc_ready;
      last_valid = inst_valid;
      last_cnt   = count;
      last_pop   = inst_valid && inst_ready && !flush;
      got_pc     = inst_pc;
      got_inst   = inst_out;
      if (last_acc) sb.push_back('{pc: pc_in, inst: 32'h1000_0000 + pc_in});
      if (fl) sb.delete();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc_valid = 1'b1; pc_in = 32'h0; inst_ready = 1'b0; flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++;
         if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
         checks++;
         if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
         checks++;
         if (imem_rd !== 1'b0) begin fails++; $display("FAIL reset_imem_rd: got %b expected 0", imem_rd); end
         checks++;
         if (pc_ready !== 1'b0) begin fails++; $display("FAIL reset_pc_ready: got %b expected 0", pc_ready); end
      end
      checks++;
      if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin
         fails++; $display("FAIL reset_head: got pc=%h inst=%h expected 0/0", inst_pc, inst_out);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (pc_ready !== 1'b1) begin fails++; $display("FAIL release_pc_ready: got %b expected 1", pc_ready); end
      pc_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_streaming();
      int sent = 0, got = 0, first_acc = -1, first_valid = -1, first_pop = -1, last_pop_c = -1;
      logic [2:0] maxc = '0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         drive_cycle(sent < 4, 32'(sent * 4), 1'b1, 1'b0);
         if (last_valid && first_valid < 0) first_valid = c;
         if (last_acc) begin
            if (first_acc < 0) first_acc = c;
            sent++;
         end
         if (last_cnt > maxc) maxc = last_cnt;
         if (last_pop) begin
            if (first_pop < 0) first_pop = c;
            last_pop_c = c;
            got++;
            checks++;
            if (sb.size() == 0) begin
               fails++; $display("FAIL stream_order: got pc=%h inst=%h expected nothing", got_pc, got_inst);
            end else begin
               exp_e = sb.pop_front();
               if (got_pc !== exp_e.pc || got_inst !== exp_e.inst) begin
                  fails++; $display("FAIL stream_order: got pc=%h inst=%h expected pc=%h inst=%h",
                                    got_pc, got_inst, exp_e.pc, exp_e.inst);
               end
            end
         end
      end
      checks++;
      if (got != 4) begin fails++; $display("FAIL stream_count: got %0d expected 4", got); end
      checks++;
      if (first_valid - first_acc != 2) begin
         fails++; $display("FAIL stream_latency: got %0d expected 2", first_valid - first_acc);
      end
      checks++;
      if (last_pop_c - first_pop != 3) begin
         fails++; $display("FAIL stream_rate: got %0d cycles for 4 outputs expected 3", last_pop_c - first_pop);
      end
      checks++;
      if (maxc > 3'd1) begin fails++; $display("FAIL stream_max_count: got %0d expected <=1", maxc); end
   endtask

   task automatic test_backpressure();
      int acc_n = 0, got = 0;
      for (int c = 0; c < 10; c++) begin
         drive_cycle(1'b1, 32'h200 + 32'(acc_n * 4), 1'b0, 1'b0);
         if (last_acc) acc_n++;
      end
      checks++;
      if (acc_n != 4) begin fails++; $display("FAIL fill_accepts: got %0d expected 4", acc_n); end
      for (int c = 0; c < 20 && sb.size() != 0; c++) begin
         drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
         if (c == 0) begin
            checks++;
            if (last_rdy !== 1'b0 || last_cnt !== 3'd4) begin
               fails++; $display("FAIL full_state: got pc_ready=%b count=%0d expected 0/4", last_rdy, last_cnt);
            end
         end
         if (c == 1) begin
            checks++;
            if (last_rdy !== 1'b1) begin fails++; $display("FAIL ready_after_pop: got %b expected 1", last_rdy); end
         end
         if (last_pop) begin
            got++;
            checks++;
            exp_e = sb.pop_front();
            if (got_pc !== exp_e.pc || got_inst !== exp_e.inst) begin
               fails++; $display("FAIL drain_order: got pc=%h inst=%h expected pc=%h inst=%h",
                                 got_pc, got_inst, exp_e.pc, exp_e.inst);
            end
         end
      end
      checks++;
      if (got != 4) begin fails++; $display("FAIL drain_count: got %0d expected 4", got); end
   endtask

   task automatic test_wrap();
      int idx = 0, got = 0;
      for (int c = 0; c < 100 && got < 10; c++) begin
         drive_cycle(idx < 10, 32'h300 + 32'(idx * 4), logic'(c[0]), 1'b0);
         if (last_acc) idx++;
         if (last_pop) begin
            got++;
            checks++;
            if (sb.size() == 0) begin
               fails++; $display("FAIL wrap_order: got pc=%h inst=%h expected nothing", got_pc, got_inst);
            end else begin
               exp_e = sb.pop_front();
               if (got_pc !== exp_e.pc || got_inst !== exp_e.inst) begin
                  fails++; $display("FAIL wrap_order: got pc=%h inst=%h expected pc=%h inst=%h",
                                    got_pc, got_inst, exp_e.pc, exp_e.inst);
               end
            end
         end
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (got != 10 || last_pop || sb.size() != 0) begin
         fails++; $display("FAIL wrap_total: got %0d delivered (%0d left) expected 10 (0 left)", got, sb.size());
      end
   endtask

   task automatic test_flush();
      int got = 0;
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b1);
      checks++;
      if (last_cnt !== 3'd3) begin fails++; $display("FAIL flush_setup_count: got %0d expected 3", last_cnt); end
      drive_cycle(1'b1, 32'h40, 1'b1, 1'b0);
      checks++;
      if (last_cnt !== 3'd0 || last_valid !== 1'b0 || last_rdy !== 1'b1) begin
         fails++; $display("FAIL flush_after: got count=%0d inst_valid=%b pc_ready=%b expected 0/0/1",
                           last_cnt, last_valid, last_rdy);
      end
      for (int c = 0; c < 10 && got == 0; c++) begin
         drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
         if (last_pop) begin
            got++;
            checks++;
            if (c != 1) begin fails++; $display("FAIL flush_latency: got cycle %0d expected 1", c); end
            checks++;
            exp_e = sb.pop_front();
            if (got_pc !== 32'h40 || got_inst !== exp_e.inst) begin
               fails++; $display("FAIL flush_new_pc: got pc=%h inst=%h expected pc=00000040 inst=%h",
                                 got_pc, got_inst, exp_e.inst);
            end
         end
      end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (got != 1 || last_valid !== 1'b0) begin
         fails++; $display("FAIL flush_stale: got %0d deliveries valid=%b expected 1/0", got, last_valid);
      end
   endtask

   task automatic test_push_pop();
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (last_cnt !== 3'd2 || !last_pop) begin
         fails++; $display("FAIL pp_before: got count=%0d pop=%b expected 2/1", last_cnt, last_pop);
      end
      checks++;
      exp_e = sb.pop_front();
      if (got_pc !== exp_e.pc || got_inst !== exp_e.inst) begin
         fails++; $display("FAIL pp_pop: got pc=%h inst=%h expected pc=%h inst=%h", got_pc, got_inst, exp_e.pc, exp_e.inst);
      end
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (last_cnt !== 3'd2) begin fails++; $display("FAIL pp_count: got %0d expected 2", last_cnt); end
      checks++;
      if (got_pc !== 32'h504) begin fails++; $display("FAIL pp_head: got %h expected 00000504", got_pc); end
      for (int c = 0; c < 10 && sb.size() != 0; c++) begin
         drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
         if (last_pop) begin
            checks++;
            exp_e = sb.pop_front();
            if (got_pc !== exp_e.pc || got_inst !== exp_e.inst) begin
               fails++; $display("FAIL pp_drain: got pc=%h inst=%h expected pc=%h inst=%h",
                                 got_pc, got_inst, exp_e.pc, exp_e.inst);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin fails++; $display("FAIL pp_timeout: got %0d left expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_wrap();
      test_flush();
      test_push_pop();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch buffer that sits directly downstream of the program counter stage. It accepts fetch addresses from the PC, issues them to the synchronous instruction memory, and captures the returned words with their PCs. The words are queued in a small FIFO and presented to the decode stage over a valid/ready handshake. A flush input discards all queued and in-flight fetches on a branch or jump redirect.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, 32, PC/address width
- IW, 32, instruction width

- clock_in  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- pc_in  input  AW  fetch address from PC stage
- pc_valid  input  1  pc_in is a valid fetch request
- pc_ready  output  1  block accepts pc_in this cycle
- imem_addr  output  AW  instruction memory address (= pc_in)
- imem_rd  output  1  memory read strobe; data returns next cycle
- imem_data  input  IW  memory read data; valid the cycle after imem_rd
- flush  input  1  discard all queued and in-flight fetches
- inst_out  output  IW  head instruction to decode
- inst_pc  output  AW  PC of head instruction
- inst_valid  output  1  head entry valid
- inst_ready  input  1  decode consumes head this cycle
- count  output  $clog2(DEPTH)+1  number of stored entries

## Operation
- Accept occurs when pc_valid && pc_ready. imem_rd = accept (combinational). imem_addr = pc_in at all times.
- Readiness: pc_ready = reset && !flush && (count + pending) < DEPTH.
  - pending = 1 while a read is in flight.
  - A same-cycle pop does not free a slot for pc_ready.
- In-flight tracking: on accept, register pending ← 1 and pend_pc ← pc_in. With no accept, pending ← 0.
- Push: in the cycle where pending = 1 and flush = 0, write {imem_data, pend_pc} at the tail, then tail++ and count++.
- Pop: when inst_valid && inst_ready, head++ and count--.
- Push and pop in the same cycle leave count unchanged.
- inst_valid = (count != 0).
  - inst_out/inst_pc are read combinationally from the head entry.
  - They hold steady while inst_valid && !inst_ready.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush (synchronous, single cycle):
  - At the next edge, head = tail = 0, count = 0, pending = 0.
  - A response arriving in the flush cycle is dropped.
  - No accept is possible in the flush cycle.
  - A pop in the flush cycle is ignored (entries discarded anyway).
- Reset:
  - head, tail, count, pending, pend_pc = 0; storage cleared to 0.
  - Resulting outputs: inst_valid = 0, inst_out = 0, inst_pc = 0, pc_ready = 0, imem_rd = 0.
  - Reset asserted mid-operation abandons any in-flight read immediately; imem_data is ignored after release.

## Timing
- Latency:
  - Accept in cycle N → imem_data sampled in N+1 → entry visible (inst_valid = 1) in N+2 when the queue was empty.
  - Sustained throughput is 1 instruction/cycle while decode keeps inst_ready = 1.
- Full: with count + pending = DEPTH, pc_ready = 0. It returns to 1 the cycle after a pop lowers count.
- Empty: inst_valid = 0. inst_ready is ignored and count never underflows.
- Flush: flush in cycle F gives count = 0 and inst_valid = 0 in F+1. pc_ready = 1 in F+1; the first new instruction is visible at F+3.
- Release of reset is recognised at the first rising edge of clock_in with reset = 1.

## Test plan
- Reset/idle: hold reset = 0 for 3 cycles, then release, with pc_valid = 1 → during reset inst_valid = 0, count = 0, imem_rd = 0, pc_ready = 0; after release pc_ready = 1.
- Streaming: PCs 0x0,0x4,0x8,0xC on consecutive cycles, ROM returns 0x1000_0000+PC, inst_ready = 1 → inst_valid rises 2 cycles after the first accept; outputs (0x0,0x1000_0000)…(0xC,0x1000_000C) in order, one per cycle; count never exceeds 1.
- Fill/backpressure: inst_ready = 0 with continuous pc_valid →
  - exactly 4 accepts, then pc_ready = 0 and count = 4;
  - raise inst_ready → entries drain in order, and pc_ready returns to 1 the cycle after the first pop.
- Wrap-around: 10 PCs through DEPTH = 4 with inst_ready toggling every cycle → all 10 pairs delivered in order, none lost or duplicated.
- Flush mid-flight: 3 entries queued plus 1 pending, assert flush one cycle →
  - next cycle count = 0 and inst_valid = 0;
  - the pending response is never delivered;
  - new PC 0x40 is delivered as the next instruction.
- Simultaneous push/pop at count = 2 → count stays 2; head advances and the tail entry holds the new word.
